// File: rtl/array_pkg.sv
// Shared constants, state encoding and header helpers for the framed array loader.
package array_pkg;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = 4;

  localparam logic [1:0] HDR_MAGIC = 2'b10;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_HDR  = 2'b01;
  localparam logic [1:0] ERR_CHK  = 2'b10;
  localparam logic [1:0] ERR_OVR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    CHECK,
    COMMIT
  } state_t;

  // Header [7:5] carries count-1, so the result is always 1..8.
  function automatic logic [CNT_W-1:0] hdr_count(input logic [7:0] hdr);
    return CNT_W'(hdr[7:5]) + CNT_W'(1);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous pad strobe followed by a
// registered one-cycle rising-edge pulse.
module sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic pulse
);

  logic [STAGES-1:0] sync_q;
  logic              last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      last_q <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      last_q <= sync_q[STAGES-1];
      pulse  <= sync_q[STAGES-1] & ~last_q;
    end
  end

endmodule

// File: rtl/array_loader.sv
// Framed byte loader: validates header/payload/checksum, buffers the payload
// and only then commits it to the register array one write per cycle.
module array_loader #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic [7:0]               in_data,
  input  logic                     in_strobe,
  output logic                     wr_en,
  output logic [$clog2(DEPTH)-1:0] wr_addr,
  output logic [7:0]               wr_data,
  output logic                     busy,
  output logic                     frame_ok,
  output logic [1:0]               err_code
);

  import array_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);

  logic             byte_edge;
  logic             byte_valid;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] pos_q, pos_d;
  logic [AW-1:0]    base_q, base_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [7:0]       chk_q, chk_d;
  logic [7:0]       pay_q [DEPTH];
  logic             pay_we;

  logic             wr_en_d;
  logic [AW-1:0]    wr_addr_d;
  logic [7:0]       wr_data_d;
  logic             busy_d;
  logic             frame_ok_d;
  logic [1:0]       err_d;

  sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_strobe_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (in_strobe),
    .pulse    (byte_edge)
  );

  assign byte_valid = byte_edge & ena;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pos_d      = pos_q;
    base_d     = base_q;
    idx_d      = idx_q;
    chk_d      = chk_q;
    pay_we     = 1'b0;
    wr_en_d    = 1'b0;
    wr_addr_d  = '0;
    wr_data_d  = '0;
    frame_ok_d = 1'b0;
    err_d      = ERR_NONE;

    unique case (state_q)
      IDLE: begin
        if (byte_valid) begin
          if (in_data[4:3] == HDR_MAGIC) begin
            cnt_d   = hdr_count(in_data);
            base_d  = in_data[AW-1:0];
            chk_d   = in_data;
            idx_d   = '0;
            state_d = DATA;
          end else begin
            err_d = ERR_HDR;
          end
        end
      end
      DATA: begin
        if (byte_valid) begin
          pay_we = 1'b1;
          chk_d  = chk_q ^ in_data;
          idx_d  = idx_q + AW'(1);
          if (CNT_W'(idx_q) + CNT_W'(1) == cnt_q) state_d = CHECK;
        end
      end
      CHECK: begin
        if (byte_valid) begin
          if (in_data == chk_q) begin
            // First write is issued here so wr_en follows the checksum byte directly.
            wr_en_d   = 1'b1;
            wr_addr_d = base_q;
            wr_data_d = pay_q[0];
            pos_d     = CNT_W'(1);
            state_d   = COMMIT;
          end else begin
            err_d   = ERR_CHK;
            state_d = IDLE;
          end
        end
      end
      COMMIT: begin
        if (byte_valid) err_d = ERR_OVR;
        if (pos_q == cnt_q) begin
          frame_ok_d = 1'b1;
          state_d    = IDLE;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = base_q + pos_q[AW-1:0];
          wr_data_d = pay_q[pos_q[AW-1:0]];
          pos_d     = pos_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (!ena) begin
      state_d    = IDLE;
      wr_en_d    = 1'b0;
      frame_ok_d = 1'b0;
      err_d      = ERR_NONE;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pos_q    <= '0;
      base_q   <= '0;
      idx_q    <= '0;
      chk_q    <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      frame_ok <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pos_q    <= pos_d;
      base_q   <= base_d;
      idx_q    <= idx_d;
      chk_q    <= chk_d;
      wr_en    <= wr_en_d;
      wr_addr  <= wr_addr_d;
      wr_data  <= wr_data_d;
      busy     <= busy_d;
      frame_ok <= frame_ok_d;
      err_code <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) pay_q[i] <= '0;
    end else if (pay_we) begin
      pay_q[idx_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_array_loader.sv
// Self-checking bench for array_loader: directed frames from the test plan plus
// randomized frames, checked against a frame-level reference model.
module tb_array_loader;

  typedef logic [7:0] bytes_t [$];
  typedef int unsigned cyc_q_t [$];
  typedef struct packed { logic [31:0] cyc; logic [2:0] addr; logic [7:0] data; } wr_t;
  typedef struct packed { logic [31:0] cyc; logic [1:0] code; } err_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b0;
  logic       in_strobe = 1'b0;
  logic [7:0] in_data = '0;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       frame_ok;
  logic [1:0] err_code;

  int unsigned checks = 0;
  int unsigned errs = 0;
  int unsigned cyc = 0;

  wr_t         got_wr[$], exp_wr[$];
  err_t        got_err[$], exp_err[$];
  int unsigned got_fok[$], exp_fok[$];

  array_loader #(
    .DEPTH       (8),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .in_data   (in_data),
    .in_strobe (in_strobe),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .frame_ok  (frame_ok),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed events, stamped with the cycle number, sampled on the falling edge.
  always @(negedge clk) begin
    wr_t  w;
    err_t e;
    if (wr_en) begin
      w.cyc = cyc; w.addr = wr_addr; w.data = wr_data;
      got_wr.push_back(w);
    end
    if (frame_ok) got_fok.push_back(cyc);
    if (err_code != 2'b00) begin
      e.cyc = cyc; e.code = err_code;
      got_err.push_back(e);
    end
  end

  // Reference model: derives expected writes/frame_ok/errors of one frame from
  // the framing rules and the cycle in which each byte's edge pulse lands.
  function automatic void model_frame(input bytes_t fb, input cyc_q_t pc);
    logic [7:0]  hdr;
    logic [7:0]  chk;
    int unsigned cnt, base, c;
    wr_t         w;
    err_t        e;
    hdr = fb[0];
    if (hdr[4:3] != 2'b10) begin
      e.cyc = pc[0] + 1; e.code = 2'b01;
      exp_err.push_back(e);
      return;
    end
    cnt  = 32'(hdr[7:5]) + 1;
    base = 32'(hdr[2:0]);
    chk  = hdr;
    for (int unsigned j = 1; j <= cnt; j++) chk ^= fb[j];
    c = pc[cnt+1];
    if (fb[cnt+1] == chk) begin
      for (int unsigned j = 0; j < cnt; j++) begin
        w.cyc  = c + 1 + j;
        w.addr = 3'((base + j) % 8);
        w.data = fb[1+j];
        exp_wr.push_back(w);
      end
      exp_fok.push_back(c + cnt + 1);
    end else begin
      e.cyc = c + 1; e.code = 2'b10;
      exp_err.push_back(e);
    end
  endfunction

  task automatic clear_sb();
    got_wr.delete(); exp_wr.delete();
    got_err.delete(); exp_err.delete();
    got_fok.delete(); exp_fok.delete();
  endtask

  // Called at a falling edge; edge pulse lands 3 cycles after the rise.
  task automatic send_byte(input logic [7:0] b, input int hi, input int lo, output int unsigned pc);
    in_data   = b;
    in_strobe = 1'b1;
    pc        = cyc + 3;
    repeat (hi) @(negedge clk);
    in_strobe = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic send_frame(input bytes_t fb);
    cyc_q_t      pcs;
    int unsigned p;
    foreach (fb[i]) begin
      send_byte(fb[i], 4, 4, p);
      pcs.push_back(p);
    end
    repeat (6) @(negedge clk);
    model_frame(fb, pcs);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ena   = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (wr_en !== 1'b0) begin errs++; $display("FAIL reset_wr_en: got %b expected 0", wr_en); end
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (frame_ok !== 1'b0) begin errs++; $display("FAIL reset_frame_ok: got %b expected 0", frame_ok); end
    checks++; if (err_code !== 2'b00) begin errs++; $display("FAIL reset_err_code: got %b expected 00", err_code); end
    checks++; if ({wr_addr, wr_data} !== 11'd0) begin errs++; $display("FAIL reset_addr_data: got %h/%h expected 0/00", wr_addr, wr_data); end
    rst_n = 1'b1;
    ena   = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    bytes_t      fb;
    int unsigned p;
    clear_sb();
    fb = {8'h32, 8'h11, 8'h22, 8'h01};
    send_byte(fb[0], 4, 4, p);
    checks++; if (busy !== 1'b1) begin errs++; $display("FAIL basic_busy_data: got %b expected 1", busy); end
    repeat (6) @(negedge clk);
    send_frame({8'h57, 8'hA0, 8'hB0, 8'hC0, 8'h87});
    // Header byte already consumed above; model the basic frame separately.
    clear_sb();
    send_frame(fb);
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL basic_busy_end: got %b expected 0", busy); end
    checks++; if (got_wr.size() != exp_wr.size()) begin errs++; $display("FAIL basic_wr_count: got %0d expected %0d", got_wr.size(), exp_wr.size()); end
    foreach (exp_wr[i]) if (i < got_wr.size()) begin
      checks++;
      if (got_wr[i] !== exp_wr[i]) begin errs++; $display("FAIL basic_wr[%0d]: got cyc %0d addr %0d data %h, expected cyc %0d addr %0d data %h", i, got_wr[i].cyc, got_wr[i].addr, got_wr[i].data, exp_wr[i].cyc, exp_wr[i].addr, exp_wr[i].data); end
    end
    checks++; if (got_fok.size() != 1 || got_fok[0] != exp_fok[0]) begin errs++; $display("FAIL basic_frame_ok: got %0d pulses, expected 1 at cycle %0d", got_fok.size(), exp_fok[0]); end
    checks++; if (got_err.size() != 0) begin errs++; $display("FAIL basic_err: got %0d error pulses expected 0", got_err.size()); end
  endtask

  task automatic test_wrap_badchk_badhdr();
    clear_sb();
    send_frame({8'h57, 8'hA0, 8'hB0, 8'hC0, 8'h87});
    send_frame({8'h32, 8'h11, 8'h22, 8'h00});
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL badchk_busy: got %b expected 0", busy); end
    send_frame({8'h32, 8'h11, 8'h22, 8'h01});
    send_frame({8'h08});
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL badhdr_busy: got %b expected 0", busy); end
    send_frame({8'h32, 8'h11, 8'h22, 8'h01});
    checks++; if (got_wr.size() != exp_wr.size()) begin errs++; $display("FAIL mixed_wr_count: got %0d expected %0d", got_wr.size(), exp_wr.size()); end
    foreach (exp_wr[i]) if (i < got_wr.size()) begin
      checks++;
      if (got_wr[i] !== exp_wr[i]) begin errs++; $display("FAIL mixed_wr[%0d]: got cyc %0d addr %0d data %h, expected cyc %0d addr %0d data %h", i, got_wr[i].cyc, got_wr[i].addr, got_wr[i].data, exp_wr[i].cyc, exp_wr[i].addr, exp_wr[i].data); end
    end
    checks++; if (got_fok.size() != exp_fok.size()) begin errs++; $display("FAIL mixed_fok_count: got %0d expected %0d", got_fok.size(), exp_fok.size()); end
    foreach (exp_fok[i]) if (i < got_fok.size()) begin
      checks++;
      if (got_fok[i] != exp_fok[i]) begin errs++; $display("FAIL mixed_fok[%0d]: got cycle %0d expected %0d", i, got_fok[i], exp_fok[i]); end
    end
    checks++; if (got_err.size() != exp_err.size()) begin errs++; $display("FAIL mixed_err_count: got %0d expected %0d", got_err.size(), exp_err.size()); end
    foreach (exp_err[i]) if (i < got_err.size()) begin
      checks++;
      if (got_err[i] !== exp_err[i]) begin errs++; $display("FAIL mixed_err[%0d]: got cyc %0d code %b, expected cyc %0d code %b", i, got_err[i].cyc, got_err[i].code, exp_err[i].cyc, exp_err[i].code); end
    end
  endtask

  task automatic test_overrun();
    bytes_t      fb;
    cyc_q_t      pcs;
    int unsigned p, px;
    err_t        e;
    clear_sb();
    fb = {8'hF0, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'hF0};
    for (int i = 0; i < 9; i++) begin
      send_byte(fb[i], 4, 4, p);
      pcs.push_back(p);
    end
    send_byte(fb[9], 3, 3, p);
    pcs.push_back(p);
    send_byte(8'hFF, 4, 4, px);
    repeat (8) @(negedge clk);
    model_frame(fb, pcs);
    e.cyc = px + 1; e.code = 2'b11;
    exp_err.push_back(e);
    checks++; if (got_wr.size() != exp_wr.size()) begin errs++; $display("FAIL ovr_wr_count: got %0d expected %0d", got_wr.size(), exp_wr.size()); end
    foreach (exp_wr[i]) if (i < got_wr.size()) begin
      checks++;
      if (got_wr[i] !== exp_wr[i]) begin errs++; $display("FAIL ovr_wr[%0d]: got cyc %0d addr %0d data %h, expected cyc %0d addr %0d data %h", i, got_wr[i].cyc, got_wr[i].addr, got_wr[i].data, exp_wr[i].cyc, exp_wr[i].addr, exp_wr[i].data); end
    end
    checks++; if (got_fok.size() != 1 || got_fok[0] != exp_fok[0]) begin errs++; $display("FAIL ovr_frame_ok: got %0d pulses, expected 1 at cycle %0d", got_fok.size(), exp_fok[0]); end
    checks++; if (got_err.size() != 1 || got_err[0] !== exp_err[0]) begin errs++; $display("FAIL ovr_err: got %0d pulses, expected 1 code 11 at cycle %0d", got_err.size(), exp_err[0].cyc); end
  endtask

  task automatic test_abort();
    int unsigned p;
    clear_sb();
    send_byte(8'h57, 4, 4, p);
    send_byte(8'hA0, 4, 4, p);
    ena = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL abort_ena_busy: got %b expected 0", busy); end
    @(negedge clk);
    ena = 1'b1;
    @(negedge clk);
    send_frame({8'h32, 8'h11, 8'h22, 8'h01});
    send_byte(8'hF0, 4, 4, p);
    send_byte(8'h00, 4, 4, p);
    send_byte(8'h01, 4, 4, p);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || wr_en !== 1'b0) begin errs++; $display("FAIL abort_rst: got busy %b wr_en %b expected 0 0", busy, wr_en); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame({8'h57, 8'hA0, 8'hB0, 8'hC0, 8'h87});
    checks++; if (got_wr.size() != exp_wr.size()) begin errs++; $display("FAIL abort_wr_count: got %0d expected %0d", got_wr.size(), exp_wr.size()); end
    foreach (exp_wr[i]) if (i < got_wr.size()) begin
      checks++;
      if (got_wr[i] !== exp_wr[i]) begin errs++; $display("FAIL abort_wr[%0d]: got cyc %0d addr %0d data %h, expected cyc %0d addr %0d data %h", i, got_wr[i].cyc, got_wr[i].addr, got_wr[i].data, exp_wr[i].cyc, exp_wr[i].addr, exp_wr[i].data); end
    end
    checks++; if (got_fok.size() != 2) begin errs++; $display("FAIL abort_fok_count: got %0d expected 2", got_fok.size()); end
    checks++; if (got_err.size() != 0) begin errs++; $display("FAIL abort_err: got %0d error pulses expected 0", got_err.size()); end
  endtask

  task automatic test_back_to_back();
    bytes_t      fa;
    cyc_q_t      pcs;
    int unsigned p;
    clear_sb();
    fa = {8'h57, 8'hA0, 8'hB0, 8'hC0, 8'h87};
    for (int i = 0; i < 4; i++) begin
      send_byte(fa[i], 4, 4, p);
      pcs.push_back(p);
    end
    // Short checksum strobe so the next header edge coincides with frame_ok.
    send_byte(fa[4], 2, 2, p);
    pcs.push_back(p);
    model_frame(fa, pcs);
    send_frame({8'h32, 8'h11, 8'h22, 8'h01});
    checks++; if (got_wr.size() != exp_wr.size()) begin errs++; $display("FAIL b2b_wr_count: got %0d expected %0d", got_wr.size(), exp_wr.size()); end
    foreach (exp_wr[i]) if (i < got_wr.size()) begin
      checks++;
      if (got_wr[i] !== exp_wr[i]) begin errs++; $display("FAIL b2b_wr[%0d]: got cyc %0d addr %0d data %h, expected cyc %0d addr %0d data %h", i, got_wr[i].cyc, got_wr[i].addr, got_wr[i].data, exp_wr[i].cyc, exp_wr[i].addr, exp_wr[i].data); end
    end
    checks++; if (got_fok.size() != 2 || got_fok[0] != exp_fok[0] || got_fok[1] != exp_fok[1]) begin errs++; $display("FAIL b2b_frame_ok: got %0d pulses, expected at cycles %0d and %0d", got_fok.size(), exp_fok[0], exp_fok[1]); end
    checks++; if (got_err.size() != 0) begin errs++; $display("FAIL b2b_err: got %0d error pulses expected 0", got_err.size()); end
  endtask

  task automatic test_random();
    bytes_t      fb;
    logic [7:0]  h, d, chk;
    int unsigned r, cnt;
    clear_sb();
    repeat (16) begin
      fb.delete();
      r = $urandom_range(0, 9);
      if (r == 0) begin
        h = 8'($urandom);
        if (h[4:3] == 2'b10) h[3] = 1'b1;
        fb.push_back(h);
      end else begin
        cnt = $urandom_range(1, 8);
        h   = {3'(cnt - 1), 2'b10, 3'($urandom_range(0, 7))};
        chk = h;
        fb.push_back(h);
        for (int unsigned j = 0; j < cnt; j++) begin
          d = 8'($urandom);
          chk ^= d;
          fb.push_back(d);
        end
        if (r < 3) chk ^= 8'(1 << $urandom_range(0, 7));
        fb.push_back(chk);
      end
      send_frame(fb);
    end
    checks++; if (got_wr.size() != exp_wr.size()) begin errs++; $display("FAIL rand_wr_count: got %0d expected %0d", got_wr.size(), exp_wr.size()); end
    foreach (exp_wr[i]) if (i < got_wr.size()) begin
      checks++;
      if (got_wr[i] !== exp_wr[i]) begin errs++; $display("FAIL rand_wr[%0d]: got cyc %0d addr %0d data %h, expected cyc %0d addr %0d data %h", i, got_wr[i].cyc, got_wr[i].addr, got_wr[i].data, exp_wr[i].cyc, exp_wr[i].addr, exp_wr[i].data); end
    end
    checks++; if (got_fok.size() != exp_fok.size()) begin errs++; $display("FAIL rand_fok_count: got %0d expected %0d", got_fok.size(), exp_fok.size()); end
    foreach (exp_fok[i]) if (i < got_fok.size()) begin
      checks++;
      if (got_fok[i] != exp_fok[i]) begin errs++; $display("FAIL rand_fok[%0d]: got cycle %0d expected %0d", i, got_fok[i], exp_fok[i]); end
    end
    checks++; if (got_err.size() != exp_err.size()) begin errs++; $display("FAIL rand_err_count: got %0d expected %0d", got_err.size(), exp_err.size()); end
    foreach (exp_err[i]) if (i < got_err.size()) begin
      checks++;
      if (got_err[i] !== exp_err[i]) begin errs++; $display("FAIL rand_err[%0d]: got cyc %0d code %b, expected cyc %0d code %b", i, got_err[i].cyc, got_err[i].code, exp_err[i].cyc, exp_err[i].code); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap_badchk_badhdr();
    test_overrun();
    test_abort();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
